// File: rtl/id_wb.sv
// Decode/writeback stage: accepts instruction words, owns accumulators A/B, resolves branches.
// Optional macro ID_WB_TRAP_EN adds a sticky illegal-opcode trap and the oIllegal output.
//
// state | meaning
// IDLE  | ready for a new instruction word
// EXEC  | operands and opcode presented to the ALU, result captured at end of cycle
// WB    | accumulator commit, branch pulse
module id_wb #(
    parameter int          OPC_W       = 6,
    parameter logic [7:0]  ACUM_A_INIT = 8'h00,
    parameter logic [7:0]  ACUM_B_INIT = 8'h00
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iInstValid,
    input  logic [OPC_W+7:0] iInstr,
    output logic             oInstReady,
    output logic [OPC_W-1:0] oAluInstSel,
    output logic [7:0]       oAcumA,
    output logic [7:0]       oAcumB,
    output logic [7:0]       oConst,
    output logic             oExValid,
    input  logic [7:0]       iAluData,
    output logic             oBranchTaken,
`ifdef ID_WB_TRAP_EN
    output logic             oIllegal,
`endif
    output logic [7:0]       oBranchTarget
);

    localparam logic [OPC_W-1:0] ADDA  = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] ADDB  = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] SUBA  = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] ANDA  = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] ANDB  = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] ORA   = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] ORB   = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] ADDCA = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] ADDCB = OPC_W'(8'h08);
    localparam logic [OPC_W-1:0] SUBCA = OPC_W'(8'h09);
    localparam logic [OPC_W-1:0] SUBCB = OPC_W'(8'h0A);
    localparam logic [OPC_W-1:0] ANDCA = OPC_W'(8'h0B);
    localparam logic [OPC_W-1:0] ANDCB = OPC_W'(8'h0C);
    localparam logic [OPC_W-1:0] ORCA  = OPC_W'(8'h0D);
    localparam logic [OPC_W-1:0] ORCB  = OPC_W'(8'h0E);
    localparam logic [OPC_W-1:0] ASLA  = OPC_W'(8'h0F);
    localparam logic [OPC_W-1:0] ASRA  = OPC_W'(8'h10);
    localparam logic [OPC_W-1:0] BAEQ  = OPC_W'(8'h11);
    localparam logic [OPC_W-1:0] BANE  = OPC_W'(8'h12);
    localparam logic [OPC_W-1:0] BAMI  = OPC_W'(8'h13);
    localparam logic [OPC_W-1:0] BAPL  = OPC_W'(8'h14);
    localparam logic [OPC_W-1:0] BBEQ  = OPC_W'(8'h15);
    localparam logic [OPC_W-1:0] BBNE  = OPC_W'(8'h16);
    localparam logic [OPC_W-1:0] BBMI  = OPC_W'(8'h17);
    localparam logic [OPC_W-1:0] BBPL  = OPC_W'(8'h18);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state;
    logic [7:0]       aluResult;
    logic             branchCond;
    logic             wrA;
    logic             wrB;
    logic [OPC_W-1:0] instOpc;
    logic [7:0]       instConst;

    assign instOpc   = iInstr[OPC_W+7:8];
    assign instConst = iInstr[7:0];

    always_comb begin
        branchCond = 1'b0;
        case (oAluInstSel)
            BAEQ:    branchCond = (oAcumA == 8'h00);
            BANE:    branchCond = (oAcumA != 8'h00);
            BAMI:    branchCond = oAcumA[7];
            BAPL:    branchCond = ~oAcumA[7];
            BBEQ:    branchCond = (oAcumB == 8'h00);
            BBNE:    branchCond = (oAcumB != 8'h00);
            BBMI:    branchCond = oAcumB[7];
            BBPL:    branchCond = ~oAcumB[7];
            default: branchCond = 1'b0;
        endcase
    end

    always_comb begin
        wrA = 1'b0;
        wrB = 1'b0;
        case (oAluInstSel)
            ADDA, SUBA, ANDA, ORA, ADDCA, SUBCA, ANDCA, ORCA, ASLA, ASRA: wrA = 1'b1;
            ADDB, ANDB, ORB, ADDCB, SUBCB, ANDCB, ORCB:                   wrB = 1'b1;
            default: begin
                wrA = 1'b0;
                wrB = 1'b0;
            end
        endcase
    end

`ifdef ID_WB_TRAP_EN
    logic trapFlag;
    logic instLegal;

    // Opcodes are densely packed from ADDA up to BBPL.
    assign instLegal  = (instOpc <= BBPL);
    assign oIllegal   = trapFlag;
    assign oInstReady = iReset_n && (state == IDLE) && !trapFlag;
`else
    assign oInstReady = iReset_n && (state == IDLE);
`endif

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state         <= IDLE;
            oAcumA        <= ACUM_A_INIT;
            oAcumB        <= ACUM_B_INIT;
            oAluInstSel   <= '0;
            oConst        <= 8'h00;
            oExValid      <= 1'b0;
            oBranchTaken  <= 1'b0;
            oBranchTarget <= 8'h00;
            aluResult     <= 8'h00;
`ifdef ID_WB_TRAP_EN
            trapFlag      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    oBranchTaken <= 1'b0;
                    if (iInstValid && oInstReady) begin
                        oAluInstSel <= instOpc;
                        oConst      <= instConst;
                        oExValid    <= 1'b1;
                        state       <= EXEC;
`ifdef ID_WB_TRAP_EN
                        if (!instLegal) trapFlag <= 1'b1;
`endif
                    end
                end
                EXEC: begin
                    oExValid  <= 1'b0;
                    aluResult <= iAluData;
                    if (branchCond) begin
                        oBranchTaken  <= 1'b1;
                        oBranchTarget <= oConst;
                    end
                    state <= WB;
                end
                WB: begin
                    oBranchTaken <= 1'b0;
                    if (wrA) oAcumA <= aluResult;
                    if (wrB) oAcumB <= aluResult;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_wb.sv
// Directed bench for id_wb: vector table of single instructions plus back-to-back and reset-in-flight sequences.
// Drives iAluData from a small reference ALU so writebacks carry real results.
module tb_id_wb;

    localparam logic [5:0] ADDA  = 6'h00, ADDB  = 6'h01, SUBA  = 6'h02, ANDA  = 6'h03;
    localparam logic [5:0] ANDB  = 6'h04, ORA   = 6'h05, ORB   = 6'h06, ADDCA = 6'h07;
    localparam logic [5:0] ADDCB = 6'h08, SUBCA = 6'h09, SUBCB = 6'h0A, ANDCA = 6'h0B;
    localparam logic [5:0] ANDCB = 6'h0C, ORCA  = 6'h0D, ORCB  = 6'h0E, ASLA  = 6'h0F;
    localparam logic [5:0] ASRA  = 6'h10, BAEQ  = 6'h11, BANE  = 6'h12, BAMI  = 6'h13;
    localparam logic [5:0] BAPL  = 6'h14, BBEQ  = 6'h15, BBNE  = 6'h16, BBMI  = 6'h17;
    localparam logic [5:0] BBPL  = 6'h18, BADOP = 6'h3F;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iInstValid = 1'b0;
    logic [13:0] iInstr = '0;
    logic        oInstReady;
    logic [5:0]  oAluInstSel;
    logic [7:0]  oAcumA, oAcumB, oConst, iAluData, oBranchTarget;
    logic        oExValid, oBranchTaken;
`ifdef ID_WB_TRAP_EN
    logic        oIllegal;
`endif

    int total = 0;
    int bad   = 0;

    id_wb #(.OPC_W(6), .ACUM_A_INIT(8'h05), .ACUM_B_INIT(8'h00)) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iInstValid(iInstValid), .iInstr(iInstr),
        .oInstReady(oInstReady), .oAluInstSel(oAluInstSel), .oAcumA(oAcumA), .oAcumB(oAcumB),
        .oConst(oConst), .oExValid(oExValid), .iAluData(iAluData), .oBranchTaken(oBranchTaken),
`ifdef ID_WB_TRAP_EN
        .oIllegal(oIllegal),
`endif
        .oBranchTarget(oBranchTarget)
    );

    always #5 iClock = ~iClock;

    always_comb begin
        case (oAluInstSel)
            ADDA, ADDB: iAluData = oAcumA + oAcumB;
            SUBA:       iAluData = oAcumA - oAcumB;
            ANDA, ANDB: iAluData = oAcumA & oAcumB;
            ORA, ORB:   iAluData = oAcumA | oAcumB;
            ADDCA:      iAluData = oAcumA + oConst;
            ADDCB:      iAluData = oAcumB + oConst;
            SUBCA:      iAluData = oAcumA - oConst;
            SUBCB:      iAluData = oAcumB - oConst;
            ANDCA:      iAluData = oAcumA & oConst;
            ANDCB:      iAluData = oAcumB & oConst;
            ORCA:       iAluData = oAcumA | oConst;
            ORCB:       iAluData = oAcumB | oConst;
            ASLA:       iAluData = {oAcumA[6:0], 1'b0};
            ASRA:       iAluData = {oAcumA[7], oAcumA[7:1]};
            default:    iAluData = 8'hEE;
        endcase
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0] opc;
        logic [7:0] cnst;
        logic [7:0] expA;
        logic [7:0] expB;
        logic       expTaken;
        logic [7:0] expTgt;
    } vec_t;

    vec_t vecs[$];

    // One instruction through IDLE -> EXEC -> WB with cycle-by-cycle checks.
    task automatic runInstr(input int idx, input vec_t v);
        logic [7:0] preA, preB;
        int n;
        string tag;
        tag = $sformatf("v%0d", idx);
        n = 0;
        while (!oInstReady && n < 10) begin
            @(posedge iClock); #1;
            n++;
        end
        if (n >= 10) check({tag, " ready_timeout"}, 8'(oInstReady), 8'h01);
        preA = oAcumA;
        preB = oAcumB;
        iInstValid = 1'b1;
        iInstr = {v.opc, v.cnst};
        @(posedge iClock); #1;
        iInstValid = 1'b0;
        check({tag, " exec_exValid"}, 8'(oExValid), 8'h01);
        check({tag, " exec_ready"}, 8'(oInstReady), 8'h00);
        check({tag, " exec_sel"}, 8'(oAluInstSel), 8'(v.opc));
        check({tag, " exec_taken"}, 8'(oBranchTaken), 8'h00);
        @(posedge iClock); #1;
        check({tag, " wb_exValid"}, 8'(oExValid), 8'h00);
        check({tag, " wb_ready"}, 8'(oInstReady), 8'h00);
        check({tag, " wb_taken"}, 8'(oBranchTaken), 8'(v.expTaken));
        if (v.expTaken) check({tag, " wb_target"}, oBranchTarget, v.expTgt);
        check({tag, " wb_A_stable"}, oAcumA, preA);
        check({tag, " wb_B_stable"}, oAcumB, preB);
        @(posedge iClock); #1;
        check({tag, " A"}, oAcumA, v.expA);
        check({tag, " B"}, oAcumB, v.expB);
        check({tag, " idle_taken"}, 8'(oBranchTaken), 8'h00);
        check({tag, " idle_ready"}, 8'(oInstReady), 8'h01);
    endtask

    int acceptCycle[$];
    int cycleCnt = 0;
    always @(posedge iClock) begin
        cycleCnt++;
        if (iInstValid && oInstReady) acceptCycle.push_back(cycleCnt);
    end

    initial begin
        // opc, const, expA, expB, taken, target -- starting from A=05, B=00
        vecs.push_back('{ADDCB, 8'h03, 8'h05, 8'h03, 1'b0, 8'h00});
        vecs.push_back('{ADDA,  8'h00, 8'h08, 8'h03, 1'b0, 8'h00});
        vecs.push_back('{SUBCA, 8'h08, 8'h00, 8'h03, 1'b0, 8'h00});
        vecs.push_back('{BAEQ,  8'h40, 8'h00, 8'h03, 1'b1, 8'h40});
        vecs.push_back('{BANE,  8'h40, 8'h00, 8'h03, 1'b0, 8'h00});
        vecs.push_back('{ADDCB, 8'h7D, 8'h00, 8'h80, 1'b0, 8'h00});
        vecs.push_back('{BBMI,  8'h12, 8'h00, 8'h80, 1'b1, 8'h12});
        vecs.push_back('{BBPL,  8'h12, 8'h00, 8'h80, 1'b0, 8'h00});
        vecs.push_back('{SUBCB, 8'h01, 8'h00, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{BBMI,  8'h12, 8'h00, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{BBPL,  8'h22, 8'h00, 8'h7F, 1'b1, 8'h22});
        vecs.push_back('{BBNE,  8'h55, 8'h00, 8'h7F, 1'b1, 8'h55});
        vecs.push_back('{BBEQ,  8'h55, 8'h00, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{ORCA,  8'h81, 8'h81, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{BAMI,  8'h33, 8'h81, 8'h7F, 1'b1, 8'h33});
        vecs.push_back('{BAPL,  8'h33, 8'h81, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{ASRA,  8'h00, 8'hC0, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{ASLA,  8'h00, 8'h80, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{ANDCA, 8'hF0, 8'h80, 8'h7F, 1'b0, 8'h00});
        vecs.push_back('{ANDB,  8'h00, 8'h80, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{ORB,   8'h00, 8'h80, 8'h80, 1'b0, 8'h00});
        vecs.push_back('{ADDB,  8'h00, 8'h80, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{SUBA,  8'h00, 8'h80, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{ANDA,  8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{ORA,   8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{ANDCB, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{ADDCA, 8'h5A, 8'h5A, 8'h00, 1'b0, 8'h00});
`ifndef ID_WB_TRAP_EN
        vecs.push_back('{BADOP, 8'h77, 8'h5A, 8'h00, 1'b0, 8'h00});
`endif

        // Reset state
        #12;
        check("rst_A", oAcumA, 8'h05);
        check("rst_B", oAcumB, 8'h00);
        check("rst_ready", 8'(oInstReady), 8'h00);
        check("rst_exValid", 8'(oExValid), 8'h00);
        check("rst_taken", 8'(oBranchTaken), 8'h00);
        check("rst_target", oBranchTarget, 8'h00);
        check("rst_sel", 8'(oAluInstSel), 8'h00);
        check("rst_const", oConst, 8'h00);
        @(negedge iClock);
        iReset_n = 1'b1;
        #1;
        check("rel_ready", 8'(oInstReady), 8'h01);
        @(posedge iClock); #1;

        foreach (vecs[i]) runInstr(i, vecs[i]);

        // Back-to-back: valid held high, ORCB then ADDCA (A=5A, B=00)
        acceptCycle.delete();
        iInstValid = 1'b1;
        iInstr = {ORCB, 8'h0F};
        @(posedge iClock); #1;
        iInstr = {ADDCA, 8'h01};
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        check("b2b_first_B", oAcumB, 8'h0F);
        check("b2b_first_A", oAcumA, 8'h5A);
        @(posedge iClock); #1;
        iInstValid = 1'b0;
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        check("b2b_second_A", oAcumA, 8'h5B);
        check("b2b_second_B", oAcumB, 8'h0F);
        check("b2b_accepts", 8'(acceptCycle.size()), 8'h02);
        if (acceptCycle.size() == 2)
            check("b2b_spacing", 8'(acceptCycle[1] - acceptCycle[0]), 8'h03);

        // Reset asserted during EXEC of ADDA
        iInstValid = 1'b1;
        iInstr = {ADDA, 8'h00};
        @(posedge iClock); #1;
        iInstValid = 1'b0;
        check("rstexec_exValid", 8'(oExValid), 8'h01);
        #2;
        iReset_n = 1'b0;
        #1;
        check("rstexec_A", oAcumA, 8'h05);
        check("rstexec_B", oAcumB, 8'h00);
        check("rstexec_ready", 8'(oInstReady), 8'h00);
        check("rstexec_exValid0", 8'(oExValid), 8'h00);
        @(negedge iClock);
        iReset_n = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        check("rstexec_A_after", oAcumA, 8'h05);
        check("rstexec_ready_after", 8'(oInstReady), 8'h01);
        check("rstexec_taken_after", 8'(oBranchTaken), 8'h00);

`ifdef ID_WB_TRAP_EN
        check("trap_idle", 8'(oIllegal), 8'h00);
        iInstValid = 1'b1;
        iInstr = {BADOP, 8'h00};
        @(posedge iClock); #1;
        iInstValid = 1'b0;
        check("trap_set", 8'(oIllegal), 8'h01);
        repeat (4) @(posedge iClock);
        #1;
        check("trap_ready_held", 8'(oInstReady), 8'h00);
        check("trap_sticky", 8'(oIllegal), 8'h01);
        check("trap_A_nochange", oAcumA, 8'h05);
        iReset_n = 1'b0;
        #3;
        iReset_n = 1'b1;
        #1;
        check("trap_clear", 8'(oIllegal), 8'h00);
        check("trap_ready_back", 8'(oInstReady), 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_wb.md
Name: id_wb

Overview:
- Decode/writeback end of the execution path.
- Accepts instruction words through a valid/ready handshake and owns accumulators A and B.
- Drives the 6-bit instruction select, both accumulators and the constant to the execute stage. Captures the combinational ALU result and writes it back.
- Resolves conditional branches (BAEQ..BBPL) and reports taken branches to fetch.

Parameters:
- OPC_W, 6, opcode / instruction-select width; must match the shared opcode definitions.
- ACUM_A_INIT, 8'h00, reset value of accumulator A.
- ACUM_B_INIT, 8'h00, reset value of accumulator B.

Ports:
- iClock  input  1  single clock, rising edge.
- iReset_n  input  1  asynchronous, active-low reset.
- iInstValid  input  1  instruction word present.
- iInstr  input  OPC_W+8  {opcode[13:8], const[7:0]}.
- oInstReady  output  1  block can accept an instruction.
- oAluInstSel  output  OPC_W  opcode to execute stage.
- oAcumA  output  8  accumulator A to execute stage.
- oAcumB  output  8  accumulator B to execute stage.
- oConst  output  8  latched constant field.
- oExValid  output  1  execute-stage inputs valid this cycle.
- iAluData  input  8  ALU result (combinational from oAluInstSel/operands).
- oBranchTaken  output  1  one-cycle pulse, branch taken.
- oBranchTarget  output  8  target address (= latched const), valid with oBranchTaken.

Behaviour:
- Reset (async, iReset_n=0):
  - state=IDLE; oAcumA=ACUM_A_INIT, oAcumB=ACUM_B_INIT.
  - oAluInstSel=0, oConst=0, oExValid=0, oBranchTaken=0, oBranchTarget=0, oInstReady=0 while asserted.
  - Any in-flight instruction is dropped; no writeback occurs.
- FSM states IDLE, EXEC, WB:
  - IDLE: oInstReady=1. If iInstValid=1 at a rising edge, latch opcode into oAluInstSel and const into oConst, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: oInstReady=0, oExValid=1 for exactly this cycle.
    - Register iAluData into an internal result register at the end of the cycle.
    - Evaluate the branch condition from the current accumulators.
    - Go to WB.
  - WB: oInstReady=0, oExValid=0. Commit the writeback and go to IDLE.
- Latency:
  - Instruction accepted at edge N; EXEC is cycle N..N+1; WB is N+1..N+2.
  - New accumulator value is visible after edge N+2.
  - oInstReady=1 again after edge N+2, so the block accepts one instruction per 3 cycles.
- Writeback target:
  - ADDA, SUBA, ANDA, ORA, ADDCA, SUBCA, ANDCA, ORCA, ASLA, ASRA -> A.
  - ADDB, ANDB, ORB, ADDCB, SUBCB, ANDCB, ORCB -> B.
  - The written value is the 8-bit ALU result, stored as-is with no saturation.
- Branches:
  - BAEQ taken if A==0; BANE if A!=0; BAMI if A[7]==1; BAPL if A[7]==0. BBxx use B with the same conditions.
  - Taken: oBranchTaken=1 and oBranchTarget=oConst during the WB cycle only.
  - No accumulator write for any branch.
- Unknown opcode: treated as NOP. Full 3-cycle sequence, no write, no branch pulse.
- oAcumA/oAcumB change only on a WB edge, so operands are stable throughout EXEC.
- iInstValid during EXEC or WB is ignored; the sender must hold it until the handshake completes.
- iReset_n deassertion takes effect synchronously to the next edge in IDLE; the first accept is possible on the first rising edge after release.

Optional Feature:
- Macro ID_WB_TRAP_EN.
- Defined:
  - Adds output oIllegal (1 bit) and a sticky internal trap flag, both set on acceptance of an opcode outside the defined set.
  - While the trap flag is set, oInstReady is held at 0.
  - The trap flag clears only on reset.
- Undefined: oIllegal port absent; unknown opcodes behave as NOP.

Test Plan:
- Reset with ACUM_A_INIT=8'h05, ACUM_B_INIT=8'h00 -> oAcumA=8'h05, oAcumB=8'h00, oInstReady=1 after release, all pulses 0.
- A=8'h05, B=8'h03; ADDA accepted at edge N with ALU model returning 8'h08 -> oExValid high one cycle, oAcumA=8'h08 after edge N+2, B unchanged, oInstReady low for 2 cycles.
- A=0; BAEQ with const=8'h40 -> oBranchTaken=1 and oBranchTarget=8'h40 in WB cycle only; A, B unchanged. BANE with same A -> no pulse.
- B=8'h80; BBMI const=8'h12 -> taken with target 8'h12. B=8'h7F -> BBMI not taken, BBPL taken.
- Back-to-back iInstValid held high with ORCB then ADDCA -> second instruction accepted exactly 3 cycles after the first; each writes only its target accumulator.
- Reset asserted during EXEC of ADDA -> no writeback, A returns to ACUM_A_INIT. With ID_WB_TRAP_EN: opcode 6'h3F -> oIllegal=1, oInstReady stays 0 until reset.
